// File: rtl/mips_multicycle_controller_pkg.sv
// rtl/mips_multicycle_controller_pkg.sv - shared encodings and control-word decode for the multicycle MIPS controller
package mips_ctrl_pkg;

    localparam int ALU_OP_W = 3;
    localparam int STATE_W  = 4;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALU_OP_W-1:0] ALU_SLT = 3'b010;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic                pc_write;
        logic                i_or_d;
        logic                mem_read;
        logic                mem_write;
        logic                ir_write;
        logic                reg_dst;
        logic                mem_to_reg;
        logic                reg_write;
        logic                alu_src_a;
        logic [1:0]          alu_src_b;
        logic [ALU_OP_W-1:0] alu_op;
        logic [1:0]          pc_source;
    } ctrl_t;

    // Moore control word for a state; BRANCH leaves pc_write low, the top ORs in zero.
    function automatic ctrl_t decode_ctrl(input state_t s, input logic [ALU_OP_W-1:0] exec_op);
        ctrl_t c;
        c = '0;
        c.alu_op = ALU_ADD;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.ir_write  = 1'b1;
                c.alu_src_b = SRCB_FOUR;
                c.pc_source = PCSRC_ALU;
                c.pc_write  = 1'b1;
            end
            S_DECODE: c.alu_src_b = SRCB_IMM_SH2;
            S_MEMADR, S_ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                c.mem_write = 1'b1;
                c.i_or_d    = 1'b1;
            end
            S_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_REG;
                c.alu_op    = exec_op;
            end
            S_ALUWB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_REG;
                c.alu_op    = ALU_SUB;
                c.pc_source = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                c.pc_source = PCSRC_JUMP;
                c.pc_write  = 1'b1;
            end
            S_ADDIWB: c.reg_write = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mips_multicycle_controller_if.sv
// rtl/mips_multicycle_controller_if.sv - controller-to-datapath signal bundle
interface mips_multicycle_controller_if;
    import mips_ctrl_pkg::*;

    logic [5:0]          opcode;
    logic [5:0]          funct;
    logic                zero;
    logic                pc_write;
    logic                i_or_d;
    logic                mem_read;
    logic                mem_write;
    logic                ir_write;
    logic                reg_dst;
    logic                mem_to_reg;
    logic                reg_write;
    logic                alu_src_a;
    logic [1:0]          alu_src_b;
    logic [ALU_OP_W-1:0] alu_op;
    logic [1:0]          pc_source;
    logic [STATE_W-1:0]  state;

    modport master (
        input  opcode, funct, zero,
        output pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dst,
               mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, state
    );

    modport slave (
        output opcode, funct, zero,
        input  pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dst,
               mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, state
    );

endinterface

// File: rtl/mips_multicycle_controller_alu_control.sv
// rtl/mips_multicycle_controller_alu_control.sv - R-type funct to ALU operation map with legality flag
module alu_control
    import mips_ctrl_pkg::*;
(
    input  logic [5:0]          funct,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                legal
);

    always_comb begin
        alu_op = ALU_ADD;
        legal  = 1'b1;
        case (funct)
            FN_ADD:  alu_op = ALU_ADD;
            FN_SUB:  alu_op = ALU_SUB;
            FN_SLT:  alu_op = ALU_SLT;
            default: legal  = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_controller.sv
// rtl/mips_multicycle_controller.sv - multicycle MIPS control FSM for lw/sw/R-type/addi/beq/j
module mips_multicycle_controller
    import mips_ctrl_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    mips_multicycle_controller_if.master bus
);

    logic [ALU_OP_W-1:0] exec_op;
    logic                funct_legal;
    state_t              state_q;
    state_t              state_d;
    ctrl_t               ctrl_q;
    ctrl_t               ctrl_live;

    alu_control u_alu_control (
        .funct  (bus.funct),
        .alu_op (exec_op),
        .legal  (funct_legal)
    );

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = funct_legal ? S_EXEC : S_FETCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            default:  state_d = S_FETCH;
        endcase
    end

    // Control word is registered alongside the state it belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            ctrl_q  <= decode_ctrl(S_FETCH, exec_op);
        end else begin
            state_q <= state_d;
            ctrl_q  <= decode_ctrl(state_d, exec_op);
        end
    end

    // Reset masks everything at once so an abandoned instruction cannot write.
    always_comb begin
        ctrl_live = rst ? '0 : ctrl_q;
        if (!rst && state_q == S_BRANCH)
            ctrl_live.pc_write = bus.zero;
    end

    assign bus.pc_write   = ctrl_live.pc_write;
    assign bus.i_or_d     = ctrl_live.i_or_d;
    assign bus.mem_read   = ctrl_live.mem_read;
    assign bus.mem_write  = ctrl_live.mem_write;
    assign bus.ir_write   = ctrl_live.ir_write;
    assign bus.reg_dst    = ctrl_live.reg_dst;
    assign bus.mem_to_reg = ctrl_live.mem_to_reg;
    assign bus.reg_write  = ctrl_live.reg_write;
    assign bus.alu_src_a  = ctrl_live.alu_src_a;
    assign bus.alu_src_b  = ctrl_live.alu_src_b;
    assign bus.alu_op     = ctrl_live.alu_op;
    assign bus.pc_source  = ctrl_live.pc_source;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// tb/tb_mips_multicycle_controller.sv - scoreboard bench for the multicycle MIPS controller
module tb_mips_multicycle_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mips_multicycle_controller_if bus ();

    mips_multicycle_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // {state, pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source}
    localparam logic [19:0] E_RST    = {4'd0,  9'b000000000, 2'b00, 3'b000, 2'b00};
    localparam logic [19:0] E_RST_MA = {4'd2,  9'b000000000, 2'b00, 3'b000, 2'b00};
    localparam logic [19:0] E_FETCH  = {4'd0,  9'b101010000, 2'b01, 3'b000, 2'b00};
    localparam logic [19:0] E_DECODE = {4'd1,  9'b000000000, 2'b11, 3'b000, 2'b00};
    localparam logic [19:0] E_MEMADR = {4'd2,  9'b000000001, 2'b10, 3'b000, 2'b00};
    localparam logic [19:0] E_MEMRD  = {4'd3,  9'b011000000, 2'b00, 3'b000, 2'b00};
    localparam logic [19:0] E_MEMWB  = {4'd4,  9'b000000110, 2'b00, 3'b000, 2'b00};
    localparam logic [19:0] E_MEMWR  = {4'd5,  9'b010100000, 2'b00, 3'b000, 2'b00};
    localparam logic [19:0] E_EX_ADD = {4'd6,  9'b000000001, 2'b00, 3'b000, 2'b00};
    localparam logic [19:0] E_EX_SUB = {4'd6,  9'b000000001, 2'b00, 3'b001, 2'b00};
    localparam logic [19:0] E_EX_SLT = {4'd6,  9'b000000001, 2'b00, 3'b010, 2'b00};
    localparam logic [19:0] E_ALUWB  = {4'd7,  9'b000001010, 2'b00, 3'b000, 2'b00};
    localparam logic [19:0] E_BR_Z1  = {4'd8,  9'b100000001, 2'b00, 3'b001, 2'b01};
    localparam logic [19:0] E_BR_Z0  = {4'd8,  9'b000000001, 2'b00, 3'b001, 2'b01};
    localparam logic [19:0] E_JUMP   = {4'd9,  9'b100000000, 2'b00, 3'b000, 2'b10};
    localparam logic [19:0] E_ADDIEX = {4'd10, 9'b000000001, 2'b10, 3'b000, 2'b00};
    localparam logic [19:0] E_ADDIWB = {4'd11, 9'b000000010, 2'b00, 3'b000, 2'b00};

    typedef struct {
        string       name;
        logic [19:0] v;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [19:0] observed();
        return {bus.state, bus.pc_write, bus.i_or_d, bus.mem_read, bus.mem_write,
                bus.ir_write, bus.reg_dst, bus.mem_to_reg, bus.reg_write, bus.alu_src_a,
                bus.alu_src_b, bus.alu_op, bus.pc_source};
    endfunction

    task automatic step(input logic r, input logic [5:0] op, input logic [5:0] fn,
                        input logic z, input string name, input logic [19:0] e);
        exp_t x;
        @(posedge clk);
        #1;
        rst        = r;
        bus.opcode = op;
        bus.funct  = fn;
        bus.zero   = z;
        x.name = name;
        x.v    = e;
        sb_q.push_back(x);
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t x;
            logic [19:0] g;
            x = sb_q.pop_front();
            g = observed();
            n_checks++;
            if (g !== x.v) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", x.name, g, x.v);
            end
            n_checks++;
            if ((bus.pc_write && bus.mem_write) || (bus.reg_write && bus.mem_write)) begin
                n_fail++;
                $display("FAIL exclusive_%s: pc_write=%b reg_write=%b mem_write=%b expected no overlap",
                         x.name, bus.pc_write, bus.reg_write, bus.mem_write);
            end
        end
    end

    initial begin
        bus.opcode = 6'b000000;
        bus.funct  = 6'b000000;
        bus.zero   = 1'b0;

        step(1'b1, 6'b000000, 6'b000000, 1'b0, "rst_c0", E_RST);
        step(1'b1, 6'b000000, 6'b000000, 1'b0, "rst_c1", E_RST);

        step(1'b0, 6'b100011, 6'b000000, 1'b1, "lw_fetch",  E_FETCH);
        step(1'b0, 6'b100011, 6'b000000, 1'b1, "lw_decode", E_DECODE);
        step(1'b0, 6'b100011, 6'b000000, 1'b1, "lw_memadr", E_MEMADR);
        step(1'b0, 6'b100011, 6'b000000, 1'b1, "lw_memrd",  E_MEMRD);
        step(1'b0, 6'b100011, 6'b000000, 1'b1, "lw_memwb",  E_MEMWB);

        step(1'b0, 6'b000000, 6'b101010, 1'b0, "slt_fetch",  E_FETCH);
        step(1'b0, 6'b000000, 6'b101010, 1'b0, "slt_decode", E_DECODE);
        step(1'b0, 6'b000000, 6'b101010, 1'b0, "slt_exec",   E_EX_SLT);
        step(1'b0, 6'b000000, 6'b101010, 1'b0, "slt_aluwb",  E_ALUWB);

        step(1'b0, 6'b000000, 6'b100010, 1'b0, "sub_fetch",  E_FETCH);
        step(1'b0, 6'b000000, 6'b100010, 1'b0, "sub_decode", E_DECODE);
        step(1'b0, 6'b000000, 6'b100010, 1'b0, "sub_exec",   E_EX_SUB);
        step(1'b0, 6'b000000, 6'b100010, 1'b0, "sub_aluwb",  E_ALUWB);

        step(1'b0, 6'b000000, 6'b100000, 1'b0, "add_fetch",  E_FETCH);
        step(1'b0, 6'b000000, 6'b100000, 1'b0, "add_decode", E_DECODE);
        step(1'b0, 6'b000000, 6'b100000, 1'b0, "add_exec",   E_EX_ADD);
        step(1'b0, 6'b000000, 6'b100000, 1'b0, "add_aluwb",  E_ALUWB);

        step(1'b0, 6'b000100, 6'b000000, 1'b1, "beq1_fetch",  E_FETCH);
        step(1'b0, 6'b000100, 6'b000000, 1'b1, "beq1_decode", E_DECODE);
        step(1'b0, 6'b000100, 6'b000000, 1'b1, "beq1_branch", E_BR_Z1);

        step(1'b0, 6'b000100, 6'b000000, 1'b0, "beq0_fetch",  E_FETCH);
        step(1'b0, 6'b000100, 6'b000000, 1'b0, "beq0_decode", E_DECODE);
        step(1'b0, 6'b000100, 6'b000000, 1'b0, "beq0_branch", E_BR_Z0);

        step(1'b0, 6'b111111, 6'b000000, 1'b0, "nop_op_fetch",  E_FETCH);
        step(1'b0, 6'b111111, 6'b000000, 1'b0, "nop_op_decode", E_DECODE);

        step(1'b0, 6'b000000, 6'b000000, 1'b0, "nop_fn_fetch",  E_FETCH);
        step(1'b0, 6'b000000, 6'b000000, 1'b0, "nop_fn_decode", E_DECODE);

        step(1'b0, 6'b001000, 6'b000000, 1'b0, "addi_fetch",  E_FETCH);
        step(1'b0, 6'b001000, 6'b000000, 1'b0, "addi_decode", E_DECODE);
        step(1'b0, 6'b001000, 6'b000000, 1'b0, "addi_ex",     E_ADDIEX);
        step(1'b0, 6'b001000, 6'b000000, 1'b0, "addi_wb",     E_ADDIWB);

        step(1'b0, 6'b101011, 6'b000000, 1'b0, "sw_fetch",  E_FETCH);
        step(1'b0, 6'b101011, 6'b000000, 1'b0, "sw_decode", E_DECODE);
        step(1'b0, 6'b101011, 6'b000000, 1'b0, "sw_memadr", E_MEMADR);
        step(1'b0, 6'b101011, 6'b000000, 1'b0, "sw_memwr",  E_MEMWR);

        step(1'b0, 6'b101011, 6'b000000, 1'b0, "swr_fetch",  E_FETCH);
        step(1'b0, 6'b101011, 6'b000000, 1'b0, "swr_decode", E_DECODE);
        step(1'b1, 6'b101011, 6'b000000, 1'b0, "swr_rst",    E_RST_MA);

        step(1'b0, 6'b000010, 6'b000000, 1'b0, "j_fetch",  E_FETCH);
        step(1'b0, 6'b000010, 6'b000000, 1'b0, "j_decode", E_DECODE);
        step(1'b0, 6'b000010, 6'b000000, 1'b0, "j_jump",   E_JUMP);
        step(1'b0, 6'b000000, 6'b000000, 1'b0, "post_j_fetch", E_FETCH);

        for (int i = 0; i < 10 && sb_q.size() > 0; i++)
            @(negedge clk);
        #1;
        if (sb_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
